// File: rtl/i2c_passthru_bitrx_pkg.sv
// i2c_passthru_pkg
//   Shared definitions for the I2C passthru bit receiver: state encoding,
//   timer defaults/widths and a small helper that decides, from the state
//   being entered, whether the source SCL line is held low.
package i2c_passthru_pkg;

  localparam int F_REF_T_SU_DAT       = 2;
  localparam int F_REF_T_LOW          = 38;
  localparam int WIDTH_F_REF_T_SU_DAT = 2;
  localparam int WIDTH_F_REF_T_LOW    = 6;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOW_HOLD  = 4'd1,
    ST_LOW_VALID = 4'd2,
    ST_RELEASE   = 4'd3,
    ST_HIGH      = 4'd4,
    ST_MID       = 4'd5,
    ST_MID2      = 4'd6,
    ST_VIOLATION = 4'd7
  } state_e;

  // SCL is stretched only while waiting for / holding the low phase.
  function automatic logic scl_held_low(input state_e st);
    return (st == ST_LOW_HOLD) || (st == ST_LOW_VALID);
  endfunction

endpackage

// File: rtl/i2c_passthru_bitrx_if.sv
// i2c_passthru_bitrx_if
//   Bus bundle between the bit receiver and its environment.
//   i_f_ref   : timing reference, rising edges counted
//   i_scl/sda : synchronised source-bus pad inputs
//   i_tx_done : downstream transmitter has replayed the previous bit
//   o_scl/sda : source-bus drives (0 = pull low, 1 = release)
//   o_rx_*    : per-bit report to the transmitter
//   o_violation : sticky protocol violation flag
//   Modport slave is the receiver side, master the environment side.
interface i2c_passthru_bitrx_if;
  logic i_f_ref;
  logic i_scl;
  logic i_sda;
  logic i_tx_done;
  logic o_scl;
  logic o_sda;
  logic o_rx_sda_init_valid;
  logic o_rx_sda_init;
  logic o_rx_sda_mid_change;
  logic o_rx_sda_final;
  logic o_rx_done;
  logic o_violation;

  modport slave (
    input  i_f_ref, i_scl, i_sda, i_tx_done,
    output o_scl, o_sda, o_rx_sda_init_valid, o_rx_sda_init,
           o_rx_sda_mid_change, o_rx_sda_final, o_rx_done, o_violation
  );

  modport master (
    output i_f_ref, i_scl, i_sda, i_tx_done,
    input  o_scl, o_sda, o_rx_sda_init_valid, o_rx_sda_init,
           o_rx_sda_mid_change, o_rx_sda_final, o_rx_done, o_violation
  );
endinterface

// File: rtl/i2c_passthru_bitrx_ref_timer.sv
// i2c_passthru_ref_timer
//   Down-counter in units of reference pulses. Reload has priority over
//   decrement; the count saturates at zero and o_tc flags zero.
//   Ports: i_clk, i_rstn (async, active low), i_reload, i_pulse_ref, o_tc.
module i2c_passthru_ref_timer #(
  parameter int WIDTH = 6,
  parameter int LOAD  = 38
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_reload,
  input  logic i_pulse_ref,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] LOAD_V = WIDTH'(LOAD);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Reload / decrement-to-zero counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_r <= ZERO_V;
    end else if (i_reload) begin
      count_r <= LOAD_V;
    end else if (i_pulse_ref && (count_r != ZERO_V)) begin
      count_r <= count_r - ONE_V;
    end else begin
      count_r <= count_r;
    end
  end

  assign o_tc = (count_r == ZERO_V);

endmodule

// File: rtl/i2c_passthru_bitrx.sv
// i2c_passthru_bitrx
//   Source-side bit receiver of the I2C passthru. Stretches source SCL low
//   until the downstream transmitter is ready, latches the bit's initial SDA,
//   tracks SDA changes while SCL is high (START/STOP/repeated START) and
//   reports init / mid-change / final / done for replay on the target bus.
//   Ports: i_clk, i_rstn (async, active low), bus (slave modport carrying
//   f_ref, pad inputs, tx_done and all registered outputs).
module i2c_passthru_bitrx
  import i2c_passthru_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rstn,
  i2c_passthru_bitrx_if.slave  bus
);

  state_e state_r, state_nxt_s;
  logic prev_f_ref_r, prev_scl_r, prev_sda_r;
  logic scl_r, sda_r, init_valid_r, init_r, mid_change_r, final_r, done_r, violation_r;
  logic init_valid_nxt_s, init_nxt_s, mid_change_nxt_s, final_nxt_s, done_nxt_s;
  logic pulse_ref_s, scl_fall_s, sda_change_s, sda_fall_s;
  logic reload_low_s, tc_su_s, tc_low_s;

  assign pulse_ref_s  = bus.i_f_ref & ~prev_f_ref_r;
  assign scl_fall_s   = prev_scl_r & ~bus.i_scl;
  assign sda_change_s = bus.i_sda ^ prev_sda_r;
  assign sda_fall_s   = prev_sda_r & ~bus.i_sda;

  // SDA setup timer restarts on every SDA edge.
  i2c_passthru_ref_timer #(.WIDTH(WIDTH_F_REF_T_SU_DAT), .LOAD(F_REF_T_SU_DAT)) u_timer_su (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_reload(sda_change_s),
    .i_pulse_ref(pulse_ref_s), .o_tc(tc_su_s)
  );

  // Low-hold / STOP-settle timer, restarted by the state machine.
  i2c_passthru_ref_timer #(.WIDTH(WIDTH_F_REF_T_LOW), .LOAD(F_REF_T_LOW)) u_timer_low (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_reload(reload_low_s),
    .i_pulse_ref(pulse_ref_s), .o_tc(tc_low_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_nxt_s      = state_r;
    init_valid_nxt_s = init_valid_r;
    init_nxt_s       = init_r;
    mid_change_nxt_s = mid_change_r;
    final_nxt_s      = final_r;
    done_nxt_s       = done_r;
    reload_low_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        done_nxt_s = 1'b1;
        if (scl_fall_s) begin
          state_nxt_s = ST_LOW_HOLD;
        end else if (sda_fall_s && bus.i_scl) begin
          // START from idle: treat as a bit with init=1 that changed once.
          init_nxt_s       = 1'b1;
          init_valid_nxt_s = 1'b1;
          mid_change_nxt_s = 1'b1;
          done_nxt_s       = 1'b0;
          reload_low_s     = 1'b1;
          state_nxt_s      = ST_MID;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOW_HOLD: begin
        if (tc_su_s && bus.i_tx_done) begin
          init_nxt_s       = bus.i_sda;
          init_valid_nxt_s = 1'b1;
          mid_change_nxt_s = 1'b0;
          done_nxt_s       = 1'b0;
          reload_low_s     = 1'b1;
          state_nxt_s      = ST_LOW_VALID;
        end else begin
          state_nxt_s = ST_LOW_HOLD;
        end
      end
      ST_LOW_VALID: begin
        if (sda_change_s) begin
          state_nxt_s = ST_VIOLATION;
        end else if (tc_low_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_LOW_VALID;
        end
      end
      ST_RELEASE: begin
        // No timeout: the far side may keep stretching.
        if (bus.i_scl) begin
          state_nxt_s = ST_HIGH;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      ST_HIGH: begin
        // SCL fall wins over a coincident SDA edge (data moves after clock).
        if (scl_fall_s) begin
          final_nxt_s      = init_r;
          done_nxt_s       = 1'b1;
          init_valid_nxt_s = 1'b0;
          state_nxt_s      = ST_LOW_HOLD;
        end else if (bus.i_sda != init_r) begin
          mid_change_nxt_s = 1'b1;
          reload_low_s     = 1'b1;
          state_nxt_s      = ST_MID;
        end else begin
          state_nxt_s = ST_HIGH;
        end
      end
      ST_MID: begin
        if (scl_fall_s) begin
          final_nxt_s      = ~init_r;
          done_nxt_s       = 1'b1;
          init_valid_nxt_s = 1'b0;
          state_nxt_s      = ST_LOW_HOLD;
        end else if (sda_change_s) begin
          reload_low_s = 1'b1;
          state_nxt_s  = ST_MID2;
        end else if (tc_low_s && bus.i_scl && bus.i_sda) begin
          // STOP settled: bus is free again.
          final_nxt_s      = 1'b1;
          done_nxt_s       = 1'b1;
          init_valid_nxt_s = 1'b0;
          state_nxt_s      = ST_IDLE;
        end else begin
          state_nxt_s = ST_MID;
        end
      end
      ST_MID2: begin
        if (scl_fall_s) begin
          final_nxt_s      = init_r;
          done_nxt_s       = 1'b1;
          init_valid_nxt_s = 1'b0;
          state_nxt_s      = ST_LOW_HOLD;
        end else if (sda_change_s) begin
          state_nxt_s = ST_VIOLATION;
        end else begin
          state_nxt_s = ST_MID2;
        end
      end
      ST_VIOLATION: begin
        done_nxt_s  = 1'b0;
        state_nxt_s = ST_VIOLATION;
      end
      default: begin
        done_nxt_s  = 1'b0;
        state_nxt_s = ST_VIOLATION;
      end
    endcase
  end

  // State, edge-history and registered output update.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r      <= ST_IDLE;
      prev_f_ref_r <= 1'b0;
      prev_scl_r   <= 1'b1;
      prev_sda_r   <= 1'b1;
      scl_r        <= 1'b1;
      sda_r        <= 1'b1;
      init_valid_r <= 1'b0;
      init_r       <= 1'b1;
      mid_change_r <= 1'b0;
      final_r      <= 1'b1;
      done_r       <= 1'b1;
      violation_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      prev_f_ref_r <= bus.i_f_ref;
      prev_scl_r   <= bus.i_scl;
      prev_sda_r   <= bus.i_sda;
      scl_r        <= ~scl_held_low(state_nxt_s);
      sda_r        <= 1'b1;
      init_valid_r <= init_valid_nxt_s;
      init_r       <= init_nxt_s;
      mid_change_r <= mid_change_nxt_s;
      final_r      <= final_nxt_s;
      done_r       <= (state_nxt_s == ST_VIOLATION) ? 1'b0 : done_nxt_s;
      violation_r  <= (state_nxt_s == ST_VIOLATION);
    end
  end

  assign bus.o_scl               = scl_r;
  assign bus.o_sda               = sda_r;
  assign bus.o_rx_sda_init_valid = init_valid_r;
  assign bus.o_rx_sda_init       = init_r;
  assign bus.o_rx_sda_mid_change = mid_change_r;
  assign bus.o_rx_sda_final      = final_r;
  assign bus.o_rx_done           = done_r;
  assign bus.o_violation         = violation_r;

endmodule

// File: tb/tb_i2c_passthru_bitrx.sv
// tb_i2c_passthru_bitrx
//   Directed bench for the I2C passthru bit receiver. A clock-stretching
//   master drives SCL through a wired-AND with the receiver's SCL drive.
//   Expected per-bit reports are queued as stimulus is issued; a monitor
//   pops and compares on each init-latch, bit-done and violation event.
module tb_i2c_passthru_bitrx;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic f_ref = 1'b0;
  logic m_scl = 1'b1;
  logic sda = 1'b1;
  logic tx_done = 1'b1;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   ref_cnt = 0;

  logic       exp_init_q[$];
  logic [1:0] exp_done_q[$];   // {final, mid_change}
  logic       exp_viol_q[$];

  i2c_passthru_bitrx_if bus();
  assign bus.i_f_ref   = f_ref;
  assign bus.i_scl     = m_scl & bus.o_scl;
  assign bus.i_sda     = sda;
  assign bus.i_tx_done = tx_done;

  i2c_passthru_bitrx dut (.i_clk(clk), .i_rstn(rstn), .bus(bus.slave));

  always #5 clk = ~clk;
  always #40 f_ref = ~f_ref;
  always @(posedge f_ref) ref_cnt = ref_cnt + 1;

  function automatic logic [7:0] outs();
    return {bus.o_scl, bus.o_sda, bus.o_rx_sda_init_valid, bus.o_rx_sda_init,
            bus.o_rx_sda_mid_change, bus.o_rx_sda_final, bus.o_rx_done, bus.o_violation};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0: return bus.o_scl;
      1: return bus.o_rx_sda_init_valid;
      2: return bus.o_rx_done;
      default: return bus.o_violation;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    chk_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d..%0d", nm, act, lo, hi);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_for(input int sel, input logic v, input int budget, input string nm);
    int i = 0;
    while (sig(sel) !== v && i < budget) begin
      tick(1);
      i++;
    end
    if (sig(sel) !== v) begin
      chk_cnt++;
      $display("FAIL %s: timeout, actual=%0b required=%0b", nm, sig(sel), v);
    end
  endtask

  // Scoreboard monitor: compare on rising edges of the report flags.
  logic pv_iv = 1'b0, pv_done = 1'b1, pv_viol = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      pv_iv <= 1'b0; pv_done <= 1'b1; pv_viol <= 1'b0;
    end else begin
      if (bus.o_rx_sda_init_valid && !pv_iv) begin
        if (exp_init_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL init_event: actual=unexpected latch required=none");
        end else check("init_value", bus.o_rx_sda_init, exp_init_q.pop_front());
      end
      if (bus.o_rx_done && !pv_done) begin
        if (exp_done_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL done_event: actual=unexpected done required=none");
        end else check("done_final_mid", {bus.o_rx_sda_final, bus.o_rx_sda_mid_change},
                       exp_done_q.pop_front());
      end
      if (bus.o_violation && !pv_viol) begin
        if (exp_viol_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL viol_event: actual=unexpected violation required=none");
        end else check("violation", bus.o_violation, exp_viol_q.pop_front());
      end
      pv_iv <= bus.o_rx_sda_init_valid;
      pv_done <= bus.o_rx_done;
      pv_viol <= bus.o_violation;
    end
  end

  initial begin
    int r;
    logic ok;
    // 1. reset state
    tick(3);
    check("reset_outputs", outs(), 8'hD6);
    rstn = 1'b1;
    tick(5);
    check("idle_after_reset", outs(), 8'hD6);

    // START from idle: init=1, mid_change=1, then SCL fall -> final=0
    exp_init_q.push_back(1'b1);
    sda = 1'b0;
    tick(4);
    check("start_mid_change", bus.o_rx_sda_mid_change, 32'd1);
    check("start_done_low", bus.o_rx_done, 32'd0);
    tx_done = 1'b0;
    exp_done_q.push_back(2'b01);
    m_scl = 1'b0;
    #1 check("stretch_not_yet", bus.o_scl, 32'd1);
    tick(1);
    check("stretch_latency", bus.o_scl, 32'd0);
    m_scl = 1'b1;

    // 2. data bit 0: SDA setup of 2 ref edges, then 38 ref edges low hold
    exp_init_q.push_back(1'b0);
    sda = 1'b1;
    tick(1);
    sda = 1'b0;
    tx_done = 1'b1;
    r = ref_cnt;
    wait_for(1, 1'b1, 200, "wait_init_bit0");
    check_rng("su_dat_edges", ref_cnt - r, 2, 3);
    r = ref_cnt;
    wait_for(0, 1'b1, 800, "wait_release_bit0");
    check_rng("t_low_edges", ref_cnt - r, 38, 39);
    tick(10);
    exp_done_q.push_back(2'b00);
    tx_done = 1'b0;
    m_scl = 1'b0;
    tick(2);
    m_scl = 1'b1;
    sda = 1'b1;

    // 3. transmitter busy for 100 ref edges: SCL held, no latch
    exp_init_q.push_back(1'b1);
    ok = 1'b1;
    r = ref_cnt;
    while (ref_cnt - r < 100) begin
      tick(1);
      if (bus.o_scl !== 1'b0 || bus.o_rx_sda_init_valid !== 1'b0) ok = 1'b0;
    end
    check("txdone_stretch_held", ok, 32'd1);
    tx_done = 1'b1;
    r = ref_cnt;
    wait_for(1, 1'b1, 100, "wait_init_txdone");
    check_rng("txdone_latch_edges", ref_cnt - r, 0, 3);
    wait_for(0, 1'b1, 800, "wait_release_bit1");

    // 4. repeated START: init=1, SDA 1->0 while SCL high, then SCL fall
    tick(10);
    sda = 1'b0;
    tick(3);
    check("rstart_mid_change", bus.o_rx_sda_mid_change, 32'd1);
    exp_done_q.push_back(2'b01);
    m_scl = 1'b0;
    tick(2);
    m_scl = 1'b1;

    // 5. STOP: init=0, SDA 0->1 with SCL high, settles after 38 ref edges
    exp_init_q.push_back(1'b0);
    wait_for(1, 1'b1, 200, "wait_init_stop");
    wait_for(0, 1'b1, 800, "wait_release_stop");
    tick(10);
    exp_done_q.push_back(2'b11);
    sda = 1'b1;
    r = ref_cnt;
    wait_for(2, 1'b1, 800, "wait_stop_done");
    check_rng("stop_settle_edges", ref_cnt - r, 38, 39);
    tick(5);
    check("stop_idle_outputs", outs(), 8'hCE);

    // 6. SDA change during the held low phase -> sticky violation
    exp_init_q.push_back(1'b1);
    m_scl = 1'b0;
    tick(2);
    check("idle_fall_stretch", bus.o_scl, 32'd0);
    m_scl = 1'b1;
    wait_for(1, 1'b1, 200, "wait_init_viol");
    tick(3);
    exp_viol_q.push_back(1'b1);
    sda = 1'b0;
    tick(1);
    check("violation_next_cycle", bus.o_violation, 32'd1);
    sda = 1'b1;
    tick(3);
    sda = 1'b0;
    tick(20);
    check("violation_sticky", {bus.o_violation, bus.o_scl, bus.o_rx_done}, 32'd6);
    rstn = 1'b0;
    #1 check("reset_mid_violation", outs(), 8'hD6);
    tick(3);
    rstn = 1'b1;
    sda = 1'b1;
    tick(5);
    check("post_reset_idle", outs(), 8'hD6);

    check("scoreboard_drained", exp_init_q.size() + exp_done_q.size() + exp_viol_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_passthru_bitrx.md
Name: i2c_passthru_bitrx

Overview:
Bit receiver on the source side of the I2C passthru, directly upstream of the bit transmitter.
- Watches source-bus SCL/SDA and stretches source SCL low until the downstream transmitter has finished the previous bit.
- Latches the bit's initial SDA and tracks SDA changes while SCL is high (START/STOP/repeated-START).
- Reports init/mid-change/final/done to the transmitter so it can replay the bit on the target bus.

Parameters:
F_REF_T_SU_DAT, 2, i_f_ref rising edges SDA must be stable before it is latched as init.
F_REF_T_LOW, 38, i_f_ref rising edges for minimum SCL-low hold after init latch, and for STOP settle.
WIDTH_F_REF_T_SU_DAT, 2, ceil(log2(F_REF_T_SU_DAT+1)).
WIDTH_F_REF_T_LOW, 6, ceil(log2(F_REF_T_LOW+1)).

Ports:
i_clk  input  1  clock
i_rstn  input  1  asynchronous active-low reset
i_f_ref  input  1  periodic timing reference; rising edges used
i_scl  input  1  source SCL pad-in, already synchronised
i_sda  input  1  source SDA pad-in, already synchronised
i_tx_done  input  1  downstream transmitter idle / previous bit replayed
o_scl  output  1  source SCL drive (0 = pull low, 1 = release)
o_sda  output  1  source SDA drive; always 1 (receive only)
o_rx_sda_init_valid  output  1  o_rx_sda_init is valid for the current bit
o_rx_sda_init  output  1  SDA at end of SCL-low phase
o_rx_sda_mid_change  output  1  SDA changed at least once while SCL high
o_rx_sda_final  output  1  SDA at end of bit
o_rx_done  output  1  bit complete; o_rx_sda_final valid
o_violation  output  1  sticky protocol violation

Behaviour:
- Reset (async, i_rstn=0): state=ST_IDLE, o_scl=1, o_sda=1, init_valid=0, init=1, mid_change=0, final=1, done=1, violation=0, timers=0. All outputs registered.
- pulse_ref = i_f_ref rising edge (prev_f_ref registered).
- timer_su: reloads F_REF_T_SU_DAT on any i_sda change, decrements per pulse_ref, stops at 0 (tc).
- timer_low: reloads F_REF_T_LOW on state request, decrements per pulse_ref, stops at 0 (tc).
- scl_fall = prev_scl & ~i_scl.

State machine:
- ST_IDLE (bus free): o_scl=1, done=1. On scl_fall → ST_LOW_HOLD, o_scl=0 on the next cycle (1-cycle stretch latency). If i_sda falls with i_scl=1 (START) → ST_MID with init=1, init_valid=1, mid_change=1, done=0.
- ST_LOW_HOLD: o_scl=0. When timer_su tc and i_tx_done:
  - latch init=i_sda; init_valid=1, mid_change=0, done=0; reload timer_low → ST_LOW_VALID.
  - If both conditions already hold on entry, latch occurs the following cycle.
- ST_LOW_VALID: o_scl=0. An i_sda change here → ST_VIOLATION. When timer_low tc → ST_RELEASE.
- ST_RELEASE: o_scl=1. Wait for i_scl=1 (no timeout; slave may stretch) → ST_HIGH.
- ST_HIGH: i_sda≠init → mid_change=1, reload timer_low → ST_MID. On scl_fall: final=init, done=1, init_valid=0 → ST_LOW_HOLD.
- ST_MID (one change):
  - scl_fall → final=~init, done=1 → ST_LOW_HOLD (START path).
  - Another i_sda change → reload timer_low → ST_MID2.
  - timer_low tc with i_scl=1 and i_sda=1 → final=1, done=1 → ST_IDLE (STOP).
- ST_MID2 (two changes): scl_fall → final=init, done=1 → ST_LOW_HOLD. A third change → ST_VIOLATION.
- ST_VIOLATION: o_scl=1, o_violation=1, done=0. Exit only by reset.

Simultaneous events:
- scl_fall coinciding with an i_sda change in ST_HIGH/ST_MID: the change is ignored (data transition after the clock edge), scl_fall wins.
- Reset mid-bit releases SCL immediately (asynchronous).

Handshake:
- o_rx_done stays high from bit end until the next init latch.
- o_rx_sda_init_valid stays high from init latch until bit end.

Decomposition:
- Package i2c_passthru_pkg: state localparams ST_IDLE..ST_VIOLATION (4-bit encoding) and the timer defaults.
- One sub-module: i2c_passthru_ref_timer (parameterised down-counter: reload, pulse_ref decrement, saturate at 0, tc output), instantiated twice.

Test Plan:
1. Reset → o_scl=1, o_sda=1, o_rx_done=1, o_rx_sda_final=1, o_violation=0.
2. Data bit 0, i_tx_done=1, SDA stable:
   - o_scl low one cycle after SCL fall; init=0, init_valid after 2 ref edges.
   - o_scl released after 38 more ref edges.
   - On SCL fall: final=0, done=1, mid_change=0.
3. Bit with i_tx_done held 0 for 100 ref edges → o_scl held low and init_valid=0 throughout; latch occurs within 3 ref edges of i_tx_done rising.
4. Repeated START (init=1, SDA 1→0 during SCL high, then SCL fall) → mid_change=1, final=0, done=1.
5. STOP (init=0, SDA 0→1 during SCL high, SCL stays high) → after 38 ref edges: final=1, done=1, state ST_IDLE, o_scl=1.
6. SDA toggles during ST_LOW_VALID → o_violation=1 next cycle, sticky until i_rstn=0; assert reset mid-violation → all outputs return to reset values immediately.
